// File: rtl/seq_hit_reporter.sv
// seq_hit_reporter: groups serialized detector outputs into frames of
// FRAME_LEN slots, records per-frame hit count and hit mask, and queues each
// finished report in a small FWFT FIFO drained over a valid/ready handshake.
// Optional feature macro: SEQ_HIT_FIRST_EN adds rpt_first_o, the index of the
// first hit in the frame (FRAME_LEN when the frame had no hits).
module seq_hit_reporter #(
  parameter int FRAME_LEN = 8,
  parameter int DEPTH     = 4,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1),
  localparam int IDX_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 set_i,
  input  logic                 bit_vld_i,
  input  logic                 detect_i,
  output logic                 rpt_vld_o,
  input  logic                 rpt_rdy_i,
  output logic [CNT_W-1:0]     rpt_cnt_o,
  output logic [FRAME_LEN-1:0] rpt_mask_o,
`ifdef SEQ_HIT_FIRST_EN
  output logic [IDX_W-1:0]     rpt_first_o,
`endif
  output logic                 ovf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] NO_HIT   = IDX_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUSH    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]   mask_q, mask_d;
  logic                   push_s;
`ifdef SEQ_HIT_FIRST_EN
  logic                   seen_q, seen_d;
  logic [IDX_W-1:0]       first_q, first_d;
  logic [IDX_W-1:0]       first_mem_q [DEPTH];
`endif

  logic [PTR_W:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       cnt_mem_q  [DEPTH];
  logic [FRAME_LEN-1:0]   mask_mem_q [DEPTH];
  logic                   ovf_q;
  logic                   empty_s, full_s, pop_s, wr_en_s, drop_s;

  // State and frame accumulator registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      mask_q  <= {FRAME_LEN{1'b0}};
`ifdef SEQ_HIT_FIRST_EN
      seen_q  <= 1'b0;
      first_q <= NO_HIT;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
`ifdef SEQ_HIT_FIRST_EN
      seen_q  <= seen_d;
      first_q <= first_d;
`endif
    end
  end

  // Next-state logic: start on the first valid slot, leave on the last slot
  // or on an abort, and spend exactly one cycle in PUSH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (set_i && bit_vld_i) begin
          state_d = (FRAME_LEN == 1) ? ST_PUSH : ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (!set_i) begin
          state_d = ST_IDLE;
        end else if (bit_vld_i && (idx_q == LAST_IDX)) begin
          state_d = ST_PUSH;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_PUSH: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Accumulator updates and the FIFO push request.
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    push_s  = 1'b0;
`ifdef SEQ_HIT_FIRST_EN
    seen_d  = seen_q;
    first_d = first_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (set_i && bit_vld_i) begin
          idx_d     = IDX_W'(1);
          cnt_d     = CNT_W'(detect_i);
          mask_d    = {FRAME_LEN{1'b0}};
          mask_d[0] = detect_i;
`ifdef SEQ_HIT_FIRST_EN
          seen_d    = detect_i;
          first_d   = detect_i ? {IDX_W{1'b0}} : NO_HIT;
`endif
        end else begin
          idx_d = idx_q;
        end
      end
      ST_COLLECT: begin
        if (!set_i) begin
          idx_d   = {IDX_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          mask_d  = {FRAME_LEN{1'b0}};
`ifdef SEQ_HIT_FIRST_EN
          seen_d  = 1'b0;
          first_d = NO_HIT;
`endif
        end else if (bit_vld_i) begin
          for (int i = 0; i < FRAME_LEN; i++) begin
            if (idx_q == IDX_W'(i)) begin
              mask_d[i] = detect_i;
            end else begin
              mask_d[i] = mask_q[i];
            end
          end
          cnt_d = cnt_q + CNT_W'(detect_i);
          idx_d = idx_q + IDX_W'(1);
`ifdef SEQ_HIT_FIRST_EN
          if (detect_i && !seen_q) begin
            seen_d  = 1'b1;
            first_d = idx_q;
          end else begin
            seen_d  = seen_q;
          end
`endif
        end else begin
          idx_d = idx_q;
        end
      end
      ST_PUSH: begin
        push_s  = 1'b1;
        idx_d   = {IDX_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        mask_d  = {FRAME_LEN{1'b0}};
`ifdef SEQ_HIT_FIRST_EN
        seen_d  = 1'b0;
        first_d = NO_HIT;
`endif
      end
      default: begin
        idx_d   = {IDX_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        mask_d  = {FRAME_LEN{1'b0}};
      end
    endcase
  end

  // FIFO status; a pop in the same cycle frees the slot a full-FIFO push needs.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                   (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign pop_s   = !empty_s && rpt_rdy_i;
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // Report storage, pointers and the sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= {(PTR_W+1){1'b0}};
      rd_ptr_q <= {(PTR_W+1){1'b0}};
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_mem_q[i]   <= {CNT_W{1'b0}};
        mask_mem_q[i]  <= {FRAME_LEN{1'b0}};
`ifdef SEQ_HIT_FIRST_EN
        first_mem_q[i] <= {IDX_W{1'b0}};
`endif
      end
    end else begin
      if (wr_en_s) begin
        cnt_mem_q[wr_ptr_q[PTR_W-1:0]]   <= cnt_q;
        mask_mem_q[wr_ptr_q[PTR_W-1:0]]  <= mask_q;
`ifdef SEQ_HIT_FIRST_EN
        first_mem_q[wr_ptr_q[PTR_W-1:0]] <= first_q;
`endif
        wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      end
      if (drop_s) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // FWFT head presentation; fields read as zero while the FIFO is empty.
  always_comb begin
    rpt_vld_o   = !empty_s;
    ovf_o       = ovf_q;
    if (empty_s) begin
      rpt_cnt_o   = {CNT_W{1'b0}};
      rpt_mask_o  = {FRAME_LEN{1'b0}};
`ifdef SEQ_HIT_FIRST_EN
      rpt_first_o = {IDX_W{1'b0}};
`endif
    end else begin
      rpt_cnt_o   = cnt_mem_q[rd_ptr_q[PTR_W-1:0]];
      rpt_mask_o  = mask_mem_q[rd_ptr_q[PTR_W-1:0]];
`ifdef SEQ_HIT_FIRST_EN
      rpt_first_o = first_mem_q[rd_ptr_q[PTR_W-1:0]];
`endif
    end
  end

endmodule

// File: tb/tb_seq_hit_reporter.sv
// Self-checking bench for seq_hit_reporter: randomized frames checked against
// a queue-based reference model of the report FIFO.
module tb_seq_hit_reporter;

  localparam int FL = 8;
  localparam int DP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       set_s = 1'b0, bit_vld = 1'b0, detect = 1'b0, rdy = 1'b0;
  logic       rpt_vld, ovf;
  logic [3:0] rpt_cnt;
  logic [7:0] rpt_mask;
`ifdef SEQ_HIT_FIRST_EN
  logic [3:0] rpt_first;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {int cnt; logic [7:0] mask; int first;} rpt_t;
  rpt_t q[$];
  bit   ovf_m = 1'b0;

  seq_hit_reporter #(.FRAME_LEN(FL), .DEPTH(DP)) dut (
    .clk_i(clk), .rst_i(rst), .set_i(set_s), .bit_vld_i(bit_vld),
    .detect_i(detect), .rpt_vld_o(rpt_vld), .rpt_rdy_i(rdy),
    .rpt_cnt_o(rpt_cnt), .rpt_mask_o(rpt_mask),
`ifdef SEQ_HIT_FIRST_EN
    .rpt_first_o(rpt_first),
`endif
    .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  // Reference: a frame report is just the popcount, the bits themselves and
  // the lowest set position.
  function automatic rpt_t make_rpt(input logic [7:0] b);
    rpt_t r;
    r.cnt = 0; r.mask = b; r.first = FL;
    for (int i = FL - 1; i >= 0; i--) begin
      if (b[i]) begin r.cnt++; r.first = i; end
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; set_s = 1'b0; bit_vld = 1'b0; rdy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q.delete(); ovf_m = 1'b0;
  endtask

  task automatic slot(input logic d);
    @(negedge clk);
    set_s = 1'b1; bit_vld = 1'b1; detect = d;
  endtask

  // Drives one frame; inputs during the PUSH cycle are randomized (ignored).
  task automatic run_frame(input logic [7:0] bits, input int gap, input bit pop_push);
    for (int i = 0; i < FL; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          set_s = 1'b1; bit_vld = 1'b0; detect = 1'($urandom);
        end
      end
      slot(bits[i]);
    end
    @(negedge clk);
    bit_vld = 1'($urandom); detect = 1'($urandom); set_s = 1'($urandom); rdy = pop_push;
    @(negedge clk);
    if (pop_push && q.size() > 0) void'(q.pop_front());
    if (q.size() < DP) q.push_back(make_rpt(bits));
    else ovf_m = 1'b1;
    set_s = 1'b0; bit_vld = 1'b0; rdy = 1'b0;
  endtask

  // Pops every queued report, comparing each head with the model.
  task automatic drain(input string nm);
    int guard = 0;
    while (q.size() > 0 && guard < 2 * DP + 2) begin
      checks++;
      if (rpt_vld !== 1'b1 || rpt_cnt !== 4'(q[0].cnt) || rpt_mask !== q[0].mask) begin
        errors++;
        $display("FAIL %s_head got vld=%b cnt=%0d mask=%h want vld=1 cnt=%0d mask=%h",
                 nm, rpt_vld, rpt_cnt, rpt_mask, q[0].cnt, q[0].mask);
      end
`ifdef SEQ_HIT_FIRST_EN
      checks++;
      if (rpt_first !== 4'(q[0].first)) begin
        errors++;
        $display("FAIL %s_first got %0d want %0d", nm, rpt_first, q[0].first);
      end
`endif
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      void'(q.pop_front());
      guard++;
    end
    checks++;
    if (rpt_vld !== 1'b0 || rpt_cnt !== 4'd0 || rpt_mask !== 8'h00) begin
      errors++;
      $display("FAIL %s_empty got vld=%b cnt=%0d mask=%h want 0 0 00", nm, rpt_vld, rpt_cnt, rpt_mask);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (rpt_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", rpt_vld); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++;
    if (rpt_cnt !== 4'd0 || rpt_mask !== 8'h00) begin
      errors++; $display("FAIL reset_data got cnt=%0d mask=%h want 0 00", rpt_cnt, rpt_mask);
    end
    do_reset();
  endtask

  task automatic test_pattern();
    logic [7:0] bits;
    bits = 8'h24;
    for (int i = 0; i < FL; i++) slot(bits[i]);
    @(negedge clk);
    bit_vld = 1'b0; set_s = 1'b1;
    checks++;
    if (rpt_vld !== 1'b0) begin errors++; $display("FAIL pattern_early got vld=%b want 0", rpt_vld); end
    @(negedge clk);
    set_s = 1'b0;
    checks++;
    if (rpt_vld !== 1'b1 || rpt_cnt !== 4'd2 || rpt_mask !== 8'h24) begin
      errors++;
      $display("FAIL pattern_rpt got vld=%b cnt=%0d mask=%h want 1 2 24", rpt_vld, rpt_cnt, rpt_mask);
    end
`ifdef SEQ_HIT_FIRST_EN
    checks++;
    if (rpt_first !== 4'd2) begin errors++; $display("FAIL pattern_first got %0d want 2", rpt_first); end
`endif
    q.push_back(make_rpt(bits));
    drain("pattern");
  endtask

  task automatic test_gapped();
    run_frame(8'hFF, 2, 1'b0);
    checks++;
    if (rpt_vld !== 1'b1 || rpt_cnt !== 4'd8 || rpt_mask !== 8'hFF) begin
      errors++;
      $display("FAIL gapped_rpt got vld=%b cnt=%0d mask=%h want 1 8 ff", rpt_vld, rpt_cnt, rpt_mask);
    end
    drain("gapped");
  endtask

  task automatic test_abort();
    for (int i = 0; i < 3; i++) slot(1'b1);
    @(negedge clk);
    set_s = 1'b0; bit_vld = 1'($urandom);
    @(negedge clk);
    bit_vld = 1'b0;
    checks++;
    if (rpt_vld !== 1'b0) begin errors++; $display("FAIL abort_norpt got vld=%b want 0", rpt_vld); end
    run_frame(8'h00, 0, 1'b0);
    checks++;
    if (q.size() != 1 || rpt_cnt !== 4'd0 || rpt_mask !== 8'h00 || rpt_vld !== 1'b1) begin
      errors++;
      $display("FAIL abort_rpt got vld=%b cnt=%0d mask=%h want 1 0 00", rpt_vld, rpt_cnt, rpt_mask);
    end
`ifdef SEQ_HIT_FIRST_EN
    checks++;
    if (rpt_first !== 4'd8) begin errors++; $display("FAIL abort_first got %0d want 8", rpt_first); end
`endif
    drain("abort");
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    for (int k = 1; k <= 5; k++) begin
      b = 8'((16'h00FF >> (FL - k)) & 16'h00FF);
      b = (b << (k == 8 ? 0 : $urandom_range(0, FL - k)));
      run_frame(b, $urandom_range(0, 2), 1'b0);
    end
    checks++;
    if (ovf !== 1'b1 || ovf !== ovf_m) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (rpt_vld !== 1'b1 || rpt_cnt !== 4'(k)) begin
        errors++; $display("FAIL ovf_order got vld=%b cnt=%0d want 1 %0d", rpt_vld, rpt_cnt, k);
      end
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
    end
    q.delete();
    checks++;
    if (rpt_vld !== 1'b0) begin errors++; $display("FAIL ovf_drained got vld=%b want 0", rpt_vld); end
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int k = 0; k < DP; k++) run_frame(8'($urandom), 0, 1'b0);
    run_frame(8'($urandom), 1, 1'b1);
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b want 0", ovf); end
    checks++;
    if (q.size() != DP) begin errors++; $display("FAIL fullpop_model got %0d want %0d", q.size(), DP); end
    drain("fullpop");
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    run_frame(8'($urandom), 0, 1'b0);
    run_frame(8'($urandom), 0, 1'b0);
    for (int i = 0; i < 5; i++) slot(1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (rpt_vld !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL midrst got vld=%b ovf=%b want 0 0", rpt_vld, ovf);
    end
    @(negedge clk);
    set_s = 1'b0; bit_vld = 1'b0;
    rst = 1'b1;
    q.delete(); ovf_m = 1'b0;
    b = 8'($urandom);
    run_frame(b, 1, 1'b0);
    checks++;
    if (rpt_vld !== 1'b1 || rpt_mask !== b) begin
      errors++; $display("FAIL midrst_clean got vld=%b mask=%h want 1 %h", rpt_vld, rpt_mask, b);
    end
    drain("midrst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      run_frame(8'($urandom), $urandom_range(0, 3), 1'($urandom));
      checks++;
      if (ovf !== ovf_m) begin errors++; $display("FAIL rand_ovf got %b want %b", ovf, ovf_m); end
      checks++;
      if (rpt_vld !== 1'b1 || rpt_cnt !== 4'(q[0].cnt) || rpt_mask !== q[0].mask) begin
        errors++;
        $display("FAIL rand_head got vld=%b cnt=%0d mask=%h want 1 %0d %h",
                 rpt_vld, rpt_cnt, rpt_mask, q[0].cnt, q[0].mask);
      end
    end
    drain("rand");
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_gapped();
    test_abort();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
